// File: rtl/gf_pkg.sv
// gf_pkg -- shared GF(2^SIZE) definitions for the syndrome path.
//   GF_SIZE / GF_PRIM : default symbol width and primitive polynomial
//   syn_state_e       : FSM encoding for gf_syndrome_calc
//   gf_alpha_pow()    : elaboration-time alpha^e, used to build constant roots
package gf_pkg;

   localparam int         GF_SIZE = 8;
   localparam logic [8:0] GF_PRIM = 9'h11D;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } syn_state_e;

   // alpha = 2. The exponent is reduced mod the multiplicative order
   // 2^size-1, so any non-negative e is accepted. Supports size <= 15.
   function automatic logic [15:0] gf_alpha_pow(input int e, input int size,
                                                input logic [16:0] prim);
      logic [15:0] r;
      int          ord;
      ord = (1 << size) - 1;
      r   = 16'd1;
      for (int i = 0; i < (e % ord); i++) begin
         r = r << 1;
         if (r[size]) r = r ^ prim[15:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/gf_mul.sv
// gf_mul -- combinational GF(2^SIZE) multiplier, p = a * b mod PRIM.
//   a, b : operands (SIZE bits)
//   p    : product (SIZE bits)
// Shift-and-add: walk b LSB first, doubling a (xtime) each step.
module gf_mul
   import gf_pkg::*;
#(
   parameter int            SIZE = GF_SIZE,
   parameter logic [SIZE:0] PRIM = GF_PRIM
) (
   input  logic [SIZE-1:0] a,
   input  logic [SIZE-1:0] b,
   output logic [SIZE-1:0] p
);

   logic [SIZE-1:0] sh;

   always_comb begin
      p  = '0;
      sh = a;
      for (int i = 0; i < SIZE; i++) begin
         if (b[i]) p = p ^ sh;
         // Bit SIZE of PRIM is implicit: dropping the carried-out MSB
         // and folding in the low bits is the reduction.
         sh = sh[SIZE-1] ? ((sh << 1) ^ PRIM[SIZE-1:0]) : (sh << 1);
      end
   end

endmodule

// File: rtl/gf_syndrome_calc.sv
// gf_syndrome_calc -- streaming Reed-Solomon syndrome generator.
// Evaluates r(x) at alpha^(j+FCR), j=0..n, via Horner's rule, one symbol per
// cycle, highest degree first.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : symbol handshake; in_data symbol, in_last ends codeword
//   out_valid/out_ready : result handshake; result held until accepted
//   flat_s              : S_j at bits [(j+1)*SIZE-1 : j*SIZE]
//   len_err             : symbol count of the codeword != NLEN
//   syn_zero            : only with GF_SYN_ZERO_FLAG_EN -- registered all-zero flag
// The result is presented from DONE and input is blocked there, so each
// codeword costs one extra bubble cycle.
module gf_syndrome_calc
   import gf_pkg::*;
#(
   parameter int            m         = 255,
   parameter int            SIZE      = $clog2(m),
   parameter int            n         = 2,
   parameter int            flat_size = (n + 1) * SIZE,
   parameter int            NLEN      = m,
   parameter int            FCR       = 1,
   parameter logic [SIZE:0] PRIM      = GF_PRIM
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [SIZE-1:0]      in_data,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [flat_size-1:0] flat_s,
   output logic                 len_err
`ifdef GF_SYN_ZERO_FLAG_EN
   ,
   output logic                 syn_zero
`endif
);

   localparam int CW = $clog2(m + 1);

   syn_state_e             state, state_nxt;
   logic [n:0][SIZE-1:0]   acc, acc_nxt, acc_mul;
   logic [CW-1:0]          count, count_nxt;
   logic                   xfer;

   // One constant-root multiplier per syndrome.
   for (genvar j = 0; j <= n; j++) begin : g_root
      localparam logic [SIZE-1:0] ROOT =
         SIZE'(gf_alpha_pow(j + FCR, SIZE, 17'(PRIM)));
      gf_mul #(.SIZE(SIZE), .PRIM(PRIM)) u_mul (
         .a (acc[j]),
         .b (ROOT),
         .p (acc_mul[j])
      );
   end

   // rst is folded in so in_ready is low in the reset cycle itself.
   assign in_ready  = ~rst & (state != DONE);
   assign xfer      = in_valid & in_ready;
   assign out_valid = (state == DONE);
   assign flat_s    = acc;
   assign len_err   = (state == DONE) && (count != CW'(NLEN));

   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      count_nxt = count;
      case (state)
         IDLE: begin
            if (xfer) begin
               acc_nxt   = {(n + 1){in_data}};
               count_nxt = CW'(1);
               state_nxt = in_last ? DONE : ACCUM;
            end
         end
         ACCUM: begin
            if (xfer) begin
               for (int j = 0; j <= n; j++) acc_nxt[j] = acc_mul[j] ^ in_data;
               // Saturate so over-long codewords still flag len_err.
               if (count != '1) count_nxt = count + CW'(1);
               if (in_last) state_nxt = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nxt = IDLE;
               acc_nxt   = '0;
               count_nxt = '0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         acc   <= '0;
         count <= '0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         count <= count_nxt;
      end
   end

`ifdef GF_SYN_ZERO_FLAG_EN
   // Registered from next-state values so it tracks (flat_s == 0) & out_valid
   // cycle for cycle.
   always_ff @(posedge clk) begin
      if (rst) syn_zero <= 1'b0;
      else     syn_zero <= (state_nxt == DONE) && (acc_nxt == '0);
   end
`endif

endmodule

// File: tb/tb_gf_syndrome_calc.sv
// tb_gf_syndrome_calc -- directed bench for gf_syndrome_calc (n=3, NLEN=3).
// Expected results are queued as each codeword is driven and popped by a
// monitor when the DUT hands a result over.
module tb_gf_syndrome_calc;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] flat_s;
   logic        len_err;
`ifdef GF_SYN_ZERO_FLAG_EN
   logic        syn_zero;
`endif

   gf_syndrome_calc #(
      .m(255), .n(3), .NLEN(3), .FCR(1), .PRIM(9'h11D)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .flat_s    (flat_s),
      .len_err   (len_err)
`ifdef GF_SYN_ZERO_FLAG_EN
      ,
      .syn_zero  (syn_zero)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] flat;
      logic        le;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Result monitor: a handover happens at the next rising edge.
   always @(negedge clk) begin
      if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_out", 32'(out_valid), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("flat_s", flat_s, e.flat);
            chk("len_err", 32'(len_err), 32'(e.le));
`ifdef GF_SYN_ZERO_FLAG_EN
            chk("syn_zero", 32'(syn_zero), 32'(e.flat == 32'd0));
`endif
         end
      end
   end

   // Enters and leaves at posedge+1. Returns the number of stalled edges.
   task automatic send_sym(input logic [7:0] d, input logic last, input int gap,
                           output int stalls);
      logic rdy;
      bit   done;
      repeat (gap) begin @(posedge clk); #1; end
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      stalls   = 0;
      done     = 0;
      while (!done) begin
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk); #1;
         if (rdy) done = 1;
         else begin
            stalls++;
            if (stalls > 50) begin
               chk("in_ready_timeout", 32'(rdy), 32'd1);
               done = 1;
            end
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_cw(input int nsym, input logic [7:0] syms [0:4], input int gap,
                          input logic [31:0] ef, input logic ele, output int first_stalls);
      exp_t e;
      int   st;
      e.flat = ef;
      e.le   = ele;
      sb.push_back(e);
      first_stalls = 0;
      for (int k = 0; k < nsym; k++) begin
         send_sym(syms[k], (k == nsym - 1), (k == 0) ? 0 : gap, st);
         if (k == 0) first_stalls = st;
      end
   endtask

   task automatic wait_drain();
      int t = 0;
      while (sb.size() != 0 && t < 50) begin @(posedge clk); #1; t++; end
      chk("drain", 32'(sb.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      int          st, st_b;
      logic [7:0]  c_zero [0:4] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
      logic [7:0]  c_one  [0:4] = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
      logic [7:0]  c_five [0:4] = '{8'd0, 8'd0, 8'd5, 8'd0, 8'd0};
      logic [7:0]  c_short[0:4] = '{8'd0, 8'd5, 8'd0, 8'd0, 8'd0};
      logic [7:0]  c_long [0:4] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd1};

      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;

      // Reset state.
      @(posedge clk); #1;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_flat_s", flat_s, 32'd0);
      chk("rst_len_err", 32'(len_err), 32'd0);
`ifdef GF_SYN_ZERO_FLAG_EN
      chk("rst_syn_zero", 32'(syn_zero), 32'd0);
`endif
      rst = 1'b0; #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      out_ready = 1'b1;

      // 1: all-zero codeword.
      send_cw(3, c_zero, 0, 32'h00000000, 1'b0, st);
      chk("c1_latency", 32'(out_valid), 32'd1);
      wait_drain();

      // 2: r(x) = x^2.
      send_cw(3, c_one, 0, 32'h1D401004, 1'b0, st);
      chk("c2_latency", 32'(out_valid), 32'd1);
      wait_drain();

      // 3: constant 5, result held for five cycles.
      out_ready = 1'b0;
      send_cw(3, c_five, 0, 32'h05050505, 1'b0, st);
      chk("c3_latency", 32'(out_valid), 32'd1);
      repeat (5) begin
         @(negedge clk);
         chk("c3_hold_flat", flat_s, 32'h05050505);
         chk("c3_hold_valid", 32'(out_valid), 32'd1);
         chk("c3_hold_ready", 32'(in_ready), 32'd0);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_drain();

      // 4: short codeword.
      send_cw(2, c_short, 0, 32'h05050505, 1'b1, st);
      wait_drain();

      // Long codeword: count past NLEN.
      send_cw(5, c_long, 0, 32'h01010101, 1'b1, st);
      wait_drain();

      // 5: reset mid-codeword, then case 3.
      send_sym(8'd1, 1'b0, 0, st);
      send_sym(8'd0, 1'b0, 0, st);
      rst = 1'b1; #1;
      chk("c5_rst_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      chk("c5_out_valid", 32'(out_valid), 32'd0);
      chk("c5_flat_s", flat_s, 32'd0);
      send_cw(3, c_five, 0, 32'h05050505, 1'b0, st);
      wait_drain();

      // 6: input gaps, then back-to-back codewords.
      send_cw(3, c_one, 2, 32'h1D401004, 1'b0, st);
      wait_drain();
      send_cw(3, c_one, 0, 32'h1D401004, 1'b0, st);
      send_cw(3, c_five, 0, 32'h05050505, 1'b0, st_b);
      chk("c6_bubble", 32'(st_b), 32'd1);
      wait_drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
